wts_envelope_scheduler: RTL

- Time-multiplexes the single combinational ADSR envelope step datapath across NUM_CH channels.
- Holds per-channel envelope context (counter 20b, state 3b, level 7b) and latches per-channel key_on/key_release/key_off request pulses from the register interface.
- On each sample tick it sweeps every channel through the shared datapath, one channel per clock, and writes the results back.
- Sits between the register file and the mixer; the mixer consumes env_level.

---
 rtl/wts_env_pkg.sv | 15 +
 rtl/wts_env_key_latch.sv | 50 +++++
 rtl/wts_envelope_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wts_env_pkg.sv
// wts_env_pkg: shared envelope state encodings, context widths and scheduler FSM encoding.
package wts_env_pkg;
  localparam int ENV_COUNTER_W = 20;
  localparam int ENV_LEVEL_W   = 7;
  localparam logic [2:0] ENV_IDLE    = 3'd0;
  localparam logic [2:0] ENV_ATTACK  = 3'd1;
  localparam logic [2:0] ENV_DECAY   = 3'd2;
  localparam logic [2:0] ENV_SUSTAIN = 3'd3;
  localparam logic [2:0] ENV_RELEASE = 3'd4;
  typedef enum logic [1:0] {
    SCH_IDLE = 2'd0,
    SCH_STEP = 2'd1,
    SCH_DONE = 2'd2
  } sch_state_t;
endpackage

// File: rtl/wts_env_key_latch.sv
// wts_env_key_latch: per-channel pending key requests (off > on > release), cleared when serviced.
// WTS_ENV_SCHED_ALLOFF_EN adds all_off, which forces key-off on every channel.
module wts_env_key_latch #(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [NUM_CH-1:0] key_on_req,
  input  logic [NUM_CH-1:0] key_release_req,
  input  logic [NUM_CH-1:0] key_off_req,
`ifdef WTS_ENV_SCHED_ALLOFF_EN
  input  logic              all_off,
`endif
  input  logic              svc_en,
  input  logic [CH_W-1:0]   svc_ch,
  output logic [NUM_CH-1:0] pend_on,
  output logic [NUM_CH-1:0] pend_rel,
  output logic [NUM_CH-1:0] pend_off
);
  logic [NUM_CH-1:0] r_on, r_rel, r_off;
  logic [NUM_CH-1:0] w_clr, w_on, w_rel, w_off;
  always_comb begin
    w_clr = svc_en ? (NUM_CH'(1) << svc_ch) : '0;
`ifdef WTS_ENV_SCHED_ALLOFF_EN
    w_off = key_off_req | {NUM_CH{all_off}};
    w_on  = key_on_req & ~{NUM_CH{all_off}};
    w_rel = key_release_req & ~{NUM_CH{all_off}};
`else
    w_off = key_off_req;
    w_on  = key_on_req;
    w_rel = key_release_req;
`endif
  end
  // Service clears first, so a request landing in the service cycle survives.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_on  <= '0;
      r_rel <= '0;
      r_off <= '0;
    end else begin
      r_off <= w_off | (r_off & ~w_clr);
      r_on  <= ~w_off & (w_on | (r_on & ~w_clr));
      r_rel <= ~w_off & ~w_on & (w_rel | (r_rel & ~w_clr));
    end
  end
  assign pend_on  = r_on;
  assign pend_rel = r_rel;
  assign pend_off = r_off;
endmodule

// File: rtl/wts_envelope_scheduler.sv
// wts_envelope_scheduler: sweeps NUM_CH envelope contexts through one shared datapath per tick.
// WTS_ENV_SCHED_ALLOFF_EN adds the all_off input.
module wts_envelope_scheduler
  import wts_env_pkg::*;
#(
  parameter int NUM_CH = 6,
  parameter int CH_W   = 3
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          tick,
  input  logic [NUM_CH-1:0]             key_on_req,
  input  logic [NUM_CH-1:0]             key_release_req,
  input  logic [NUM_CH-1:0]             key_off_req,
`ifdef WTS_ENV_SCHED_ALLOFF_EN
  input  logic                          all_off,
`endif
  input  logic [NUM_CH*8-1:0]           reg_ar,
  input  logic [NUM_CH*8-1:0]           reg_dr,
  input  logic [NUM_CH*8-1:0]           reg_sr,
  input  logic [NUM_CH*8-1:0]           reg_rr,
  input  logic [NUM_CH*6-1:0]           reg_sl,
  output logic                          eg_key_on,
  output logic                          eg_key_release,
  output logic                          eg_key_off,
  output logic [7:0]                    eg_reg_ar,
  output logic [7:0]                    eg_reg_dr,
  output logic [7:0]                    eg_reg_sr,
  output logic [7:0]                    eg_reg_rr,
  output logic [5:0]                    eg_reg_sl,
  output logic [ENV_COUNTER_W-1:0]      eg_counter_in,
  output logic [2:0]                    eg_state_in,
  output logic [ENV_LEVEL_W-1:0]        eg_level_in,
  input  logic [ENV_COUNTER_W-1:0]      eg_counter_out,
  input  logic [2:0]                    eg_state_out,
  input  logic [ENV_LEVEL_W-1:0]        eg_level_out,
  output logic [NUM_CH*ENV_LEVEL_W-1:0] env_level,
  output logic [NUM_CH-1:0]             ch_active,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overrun
);
  sch_state_t r_state, w_state_nx;
  logic [CH_W-1:0] r_ch, w_ch_nx, w_sel;
  logic w_step, w_last;
  logic [NUM_CH-1:0] w_pon, w_prel, w_poff;
  logic [ENV_COUNTER_W-1:0] r_cnt [NUM_CH];
  logic [2:0] r_st [NUM_CH];
  logic [ENV_LEVEL_W-1:0] r_lvl [NUM_CH];
  logic [NUM_CH*ENV_LEVEL_W-1:0] r_env;
  logic [NUM_CH-1:0] r_act;
  wts_env_key_latch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_keys (
    .clk            (clk),
    .nreset         (nreset),
    .key_on_req     (key_on_req),
    .key_release_req(key_release_req),
    .key_off_req    (key_off_req),
`ifdef WTS_ENV_SCHED_ALLOFF_EN
    .all_off        (all_off),
`endif
    .svc_en         (w_step),
    .svc_ch         (r_ch),
    .pend_on        (w_pon),
    .pend_rel       (w_prel),
    .pend_off       (w_poff)
  );
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= SCH_IDLE;
      r_ch    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ch    <= w_ch_nx;
    end
  end
  always_comb begin
    w_last     = r_ch == CH_W'(NUM_CH - 1);
    w_state_nx = r_state == SCH_IDLE ? (tick ? SCH_STEP : SCH_IDLE) :
                 r_state == SCH_STEP ? (w_last ? SCH_DONE : SCH_STEP) : SCH_IDLE;
    w_ch_nx    = (r_state == SCH_STEP && !w_last) ? r_ch + 1'b1 : '0;
  end
  // Outside a sweep the datapath sees channel 0 with all keys low.
  always_comb begin
    w_step         = r_state == SCH_STEP;
    w_sel          = w_step ? r_ch : '0;
    busy           = w_step;
    frame_done     = r_state == SCH_DONE;
    overrun        = tick && r_state != SCH_IDLE;
    eg_key_on      = w_step && w_pon[w_sel];
    eg_key_release = w_step && w_prel[w_sel];
    eg_key_off     = w_step && w_poff[w_sel];
    eg_reg_ar      = reg_ar[8*w_sel +: 8];
    eg_reg_dr      = reg_dr[8*w_sel +: 8];
    eg_reg_sr      = reg_sr[8*w_sel +: 8];
    eg_reg_rr      = reg_rr[8*w_sel +: 8];
    eg_reg_sl      = reg_sl[6*w_sel +: 6];
    eg_counter_in  = r_cnt[w_sel];
    eg_state_in    = r_st[w_sel];
    eg_level_in    = r_lvl[w_sel];
  end
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
        r_st[i]  <= ENV_IDLE;
        r_lvl[i] <= '0;
      end
      r_env <= '0;
      r_act <= '0;
    end else if (w_step) begin
      r_cnt[r_ch] <= eg_counter_out;
      r_st[r_ch]  <= eg_state_out;
      r_lvl[r_ch] <= eg_level_out;
      r_env[ENV_LEVEL_W*r_ch +: ENV_LEVEL_W] <= eg_level_out;
      r_act[r_ch] <= eg_state_out != ENV_IDLE;
    end
  end
  assign env_level = r_env;
  assign ch_active = r_act;
endmodule
